// File: rtl/game_screen_ctrl_pkg.sv
// Shared definitions for the typing-game screen controller: state codes and default limits.
// The optional boss stage is selected with the BOSS_STAGE_EN macro in the top.
package game_screen_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam int DEF_WIN_SCORE     = 20;
  localparam int DEF_MAX_MISS      = 5;
  localparam int DEF_RESULT_FRAMES = 180;
  localparam int DEF_SCORE_W       = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_BOSS = 3'd2,
    ST_WIN  = 3'd3,
    ST_LOSE = 3'd4
  } state_e;

endpackage

// File: rtl/game_screen_ctrl_result_timer.sv
// Frame-tick counter with synchronous clear, tick enable and a terminal-count strobe.
// done_o fires on the tick that would take the count past TERMINAL-1; the count then wraps to 0.
module game_screen_ctrl_result_timer #(
  parameter int TERMINAL = 180
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = en_i && (cnt_q == CNT_W'(TERMINAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = done_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_screen_ctrl.sv
// Screen-level controller for the typing game: phase FSM, score/miss counters and show flags.
// Define BOSS_STAGE_EN to include the BOSS phase between PLAY and WIN.
module game_screen_ctrl
  import game_screen_ctrl_pkg::*;
#(
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int MAX_MISS      = DEF_MAX_MISS,
  parameter int RESULT_FRAMES = DEF_RESULT_FRAMES,
  parameter int SCORE_W       = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               frame_tick,
  input  logic               enter_pressed,
  input  logic               hit,
  input  logic               miss,
  input  logic               boss_cleared,
  output logic               start_show,
  output logic               boss_show,
  output logic               win_show,
  output logic               lose_show,
  output logic               game_clr,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         miss_cnt,
  output logic [STATE_W-1:0] state
);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         miss_q, miss_d;
  logic               game_clr_q, game_clr_d;
  logic               start_q, start_d;
  logic               boss_q, boss_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               in_result;
  logic               timer_done;

`ifndef BOSS_STAGE_EN
  logic unused_boss_cleared;
  assign unused_boss_cleared = boss_cleared;
`endif

  assign in_result = (state_q == ST_WIN) || (state_q == ST_LOSE);

  // Held in clear outside the result screens, so every WIN/LOSE entry starts from zero.
  game_screen_ctrl_result_timer #(
    .TERMINAL (RESULT_FRAMES)
  ) u_result_timer (
    .clk    (clk),
    .rst_n  (clrn),
    .clr_i  (!in_result),
    .en_i   (in_result && frame_tick),
    .done_o (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    miss_d     = miss_q;
    game_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enter_pressed) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          miss_d     = '0;
          game_clr_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit && (score_q != '1)) score_d = score_q + 1'b1;
        if (miss && (miss_q != 4'hF)) miss_d = miss_q + 1'b1;
        // Decisions use the updated counts; losing wins a tie with reaching the score.
        if (miss_d >= 4'(MAX_MISS)) begin
          state_d = ST_LOSE;
        end else if (score_d >= SCORE_W'(WIN_SCORE)) begin
`ifdef BOSS_STAGE_EN
          state_d = ST_BOSS;
`else
          state_d = ST_WIN;
`endif
        end
      end
`ifdef BOSS_STAGE_EN
      ST_BOSS: begin
        if (hit && (score_q != '1)) score_d = score_q + 1'b1;
        if (miss && (miss_q != 4'hF)) miss_d = miss_q + 1'b1;
        if (miss_d >= 4'(MAX_MISS)) begin
          state_d = ST_LOSE;
        end else if (boss_cleared) begin
          state_d = ST_WIN;
        end
      end
`endif
      ST_WIN, ST_LOSE: begin
        if (enter_pressed || timer_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_d = 1'b0;
    boss_d  = 1'b0;
    win_d   = 1'b0;
    lose_d  = 1'b0;
    case (state_d)
      ST_PLAY: start_d = 1'b1;
`ifdef BOSS_STAGE_EN
      ST_BOSS: begin
        start_d = 1'b1;
        boss_d  = 1'b1;
      end
`endif
      ST_WIN: begin
        start_d = 1'b1;
        win_d   = 1'b1;
      end
      ST_LOSE: begin
        start_d = 1'b1;
        lose_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      miss_q     <= '0;
      game_clr_q <= 1'b0;
      start_q    <= 1'b0;
      boss_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      miss_q     <= miss_d;
      game_clr_q <= game_clr_d;
      start_q    <= start_d;
      boss_q     <= boss_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
    end
  end

  assign start_show = start_q;
  assign win_show   = win_q;
  assign lose_show  = lose_q;
  assign game_clr   = game_clr_q;
  assign score      = score_q;
  assign miss_cnt   = miss_q;
  assign state      = state_q;
`ifdef BOSS_STAGE_EN
  assign boss_show  = boss_q;
`else
  assign boss_show  = 1'b0;
  logic unused_boss_q;
  assign unused_boss_q = boss_q;
`endif

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl with hand-computed expectations; honours BOSS_STAGE_EN.
module tb_game_screen_ctrl;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enter_pressed = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       boss_cleared = 1'b0;
  logic       start_show, boss_show, win_show, lose_show, game_clr;
  logic [7:0] score;
  logic [3:0] miss_cnt;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  game_screen_ctrl dut (
    .clk           (clk),
    .clrn          (clrn),
    .frame_tick    (frame_tick),
    .enter_pressed (enter_pressed),
    .hit           (hit),
    .miss          (miss),
    .boss_cleared  (boss_cleared),
    .start_show    (start_show),
    .boss_show     (boss_show),
    .win_show      (win_show),
    .lose_show     (lose_show),
    .game_clr      (game_clr),
    .score         (score),
    .miss_cnt      (miss_cnt),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on the selected inputs; returns at the following negedge, after the update edge.
  task automatic step(input logic e, input logic h, input logic m, input logic b, input logic f);
    @(negedge clk);
    enter_pressed = e;
    hit           = h;
    miss          = m;
    boss_cleared  = b;
    frame_tick    = f;
    @(negedge clk);
    enter_pressed = 1'b0;
    hit           = 1'b0;
    miss          = 1'b0;
    boss_cleared  = 1'b0;
    frame_tick    = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_start", 32'(start_show), 0);
    check("rst_score", 32'(score), 0);
    check("rst_miss", 32'(miss_cnt), 0);
    check("rst_clr", 32'(game_clr), 0);
    clrn = 1'b1;

    // IDLE ignores hit/miss
    step(0, 1, 1, 0, 0);
    check("idle_ign_state", 32'(state), 0);
    check("idle_ign_score", 32'(score), 0);
    check("idle_ign_miss", 32'(miss_cnt), 0);

    // Start a game
    step(1, 0, 0, 0, 0);
    check("start_state", 32'(state), 1);
    check("start_show", 32'(start_show), 1);
    check("start_clr", 32'(game_clr), 1);
    @(negedge clk);
    check("clr_one_cycle", 32'(game_clr), 0);

    // Enter and boss_cleared in PLAY are ignored
    step(1, 0, 0, 1, 0);
    check("play_ign_state", 32'(state), 1);
    check("play_ign_clr", 32'(game_clr), 0);

    for (int i = 0; i < 19; i++) step(0, 1, 0, 0, 0);
    check("play19_score", 32'(score), 19);
    check("play19_state", 32'(state), 1);
    step(0, 1, 0, 0, 0);
    check("play20_score", 32'(score), 20);
`ifdef BOSS_STAGE_EN
    check("to_boss_state", 32'(state), 2);
    check("to_boss_show", 32'(boss_show), 1);
    step(0, 1, 0, 0, 0);
    check("boss_hit_score", 32'(score), 21);
    step(0, 0, 0, 1, 0);
    check("boss_clr_state", 32'(state), 3);
    check("boss_clr_bshow", 32'(boss_show), 0);
`else
    check("to_win_state", 32'(state), 3);
    check("to_win_bshow", 32'(boss_show), 0);
`endif
    check("win_show", 32'(win_show), 1);

    // WIN held for 179 ticks, 180th returns to IDLE
    for (int i = 0; i < 179; i++) step(0, 0, 0, 0, 1);
    check("win179_state", 32'(state), 3);
    check("win179_show", 32'(win_show), 1);
    step(0, 0, 0, 0, 1);
    check("win180_state", 32'(state), 0);
    check("win180_start", 32'(start_show), 0);
    check("win180_wshow", 32'(win_show), 0);

    // Mid-game asynchronous reset with score 7
    step(1, 0, 0, 0, 0);
    check("g2_clr", 32'(game_clr), 1);
    check("g2_score", 32'(score), 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    check("g2_score7", 32'(score), 7);
    #2 clrn = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_score", 32'(score), 0);
    check("mid_rst_start", 32'(start_show), 0);
    check("mid_rst_clr", 32'(game_clr), 0);
    @(negedge clk);
    clrn = 1'b1;

    // Simultaneous hit+miss at score 19 / miss 4: LOSE wins
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 19; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    check("pre_lose_miss", 32'(miss_cnt), 4);
    check("pre_lose_state", 32'(state), 1);
    step(0, 1, 1, 0, 0);
    check("lose_state", 32'(state), 4);
    check("lose_show", 32'(lose_show), 1);
    check("lose_score", 32'(score), 20);
    check("lose_miss", 32'(miss_cnt), 5);
    check("lose_bshow", 32'(boss_show), 0);
    check("lose_wshow", 32'(win_show), 0);

    // Frozen counters in LOSE, early exit with enter
    step(0, 1, 1, 0, 0);
    check("lose_frz_score", 32'(score), 20);
    check("lose_frz_miss", 32'(miss_cnt), 5);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1);
    check("lose10_state", 32'(state), 4);
    step(1, 0, 0, 0, 0);
    check("lose_ent_state", 32'(state), 0);
    check("lose_ent_start", 32'(start_show), 0);
    check("lose_ent_lshow", 32'(lose_show), 0);
    step(1, 0, 0, 0, 0);
    check("g4_state", 32'(state), 1);
    check("g4_score", 32'(score), 0);
    check("g4_miss", 32'(miss_cnt), 0);
    check("g4_clr", 32'(game_clr), 1);

`ifdef BOSS_STAGE_EN
    // In BOSS, a miss reaching the limit beats a simultaneous boss_cleared
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    check("boss_pre_state", 32'(state), 2);
    step(0, 0, 1, 1, 0);
    check("boss_lose_state", 32'(state), 4);
    check("boss_lose_bshow", 32'(boss_show), 0);
`else
    // Result timer restarts from zero on every result screen
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    check("g4_win_state", 32'(state), 3);
    for (int i = 0; i < 179; i++) step(0, 0, 0, 0, 1);
    check("g4_win179", 32'(state), 3);
    step(0, 0, 0, 0, 1);
    check("g4_win180", 32'(state), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_screen_ctrl.md
Name: game_screen_ctrl

Overview:
- Screen-level game controller for the typing game.
- Sequences the game through its phases: start screen, play, boss, win, lose.
- Drives the show flags consumed by the display line selector. Keeps score and miss counts.
- Issues a one-cycle clear pulse to the word generator and boss logic when a new game begins.

Parameters:
WIN_SCORE, 20, hits needed in PLAY to advance (to BOSS, or to WIN when boss stage is compiled out)
MAX_MISS, 5, misses that end the game in LOSE
RESULT_FRAMES, 180, frame ticks a WIN/LOSE screen is held before returning to start (3 s at 60 Hz)
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame (vsync)
enter_pressed  in  1  one-cycle pulse, Enter key make code
hit  in  1  one-cycle pulse, word typed correctly
miss  in  1  one-cycle pulse, word reached the bottom untyped
boss_cleared  in  1  one-cycle pulse, boss word sequence completed
start_show  out  1  0 only on the start screen; 1 once a game is running or a result is shown
boss_show  out  1  1 in BOSS
win_show  out  1  1 in WIN
lose_show  out  1  1 in LOSE
game_clr  out  1  one-cycle pulse on entry to PLAY from IDLE
score  out  SCORE_W  correct words this game
miss_cnt  out  4  missed words this game
state  out  3  encoded state, for debug/LEDs

Behaviour:
- Single clock domain.
- All outputs are registered and change on the rising clk edge one cycle after the causing input pulse.
- Reset (clrn=0, async) forces:
  - state=IDLE
  - all show flags 0
  - game_clr 0
  - score 0
  - miss_cnt 0
  - result frame counter 0
- A reset asserted mid-game aborts immediately to IDLE.
- States and encodings: IDLE=0, PLAY=1, BOSS=2, WIN=3, LOSE=4. Codes 5–7 recover to IDLE next cycle.
- IDLE:
  - Outputs: start_show=0; other flags 0.
  - enter_pressed -> PLAY. Score, miss_cnt and frame counter clear. game_clr=1 for exactly that transition cycle.
  - hit, miss and boss_cleared are ignored.
- PLAY:
  - Outputs: start_show=1.
  - hit increments score, saturating at 2^SCORE_W-1.
  - miss increments miss_cnt, saturating at 15.
  - If hit and miss arrive in the same cycle, both are counted.
  - Transitions use the post-update values:
    - miss_cnt>=MAX_MISS -> LOSE. This has priority over score reaching WIN_SCORE in the same cycle.
    - Otherwise score>=WIN_SCORE -> BOSS.
  - enter_pressed is ignored.
- BOSS:
  - Outputs: start_show=1, boss_show=1.
  - miss still counts. miss_cnt>=MAX_MISS -> LOSE, with priority over a simultaneous boss_cleared.
  - boss_cleared -> WIN. hit still increments score.
- WIN / LOSE:
  - Outputs: start_show=1, and win_show or lose_show=1 respectively.
  - score and miss_cnt are frozen.
  - The frame counter is cleared on entry and increments on each frame_tick.
  - Exit to IDLE when it reaches RESULT_FRAMES-1 and a frame_tick occurs, or on enter_pressed (immediate, takes priority).
- Invariant: at most one of boss_show, win_show and lose_show is 1 in any cycle.
- Invariant: game_clr is never high for two consecutive cycles.

Optional Feature:
BOSS_STAGE_EN
- Defined: the BOSS state exists as described.
- Undefined:
  - In PLAY, score>=WIN_SCORE -> WIN directly.
  - boss_show is tied to 0.
  - boss_cleared is ignored.
  - The encoding of value 2 is unused and recovers to IDLE.

Decomposition:
- Shared package holds:
  - state encodings (ST_IDLE..ST_LOSE)
  - default WIN_SCORE, MAX_MISS and RESULT_FRAMES constants
  - the 3-bit state width
- One natural sub-module: result_timer. It is a frame-tick counter with clear, enable and terminal-count output, reusable for other timed screens.
- FSM and score logic stay in the top.

Test Plan:
- Reset mid-PLAY with score=7 -> outputs immediately 0/IDLE; score=0, miss_cnt=0; no game_clr.
- IDLE, enter_pressed -> next cycle state=PLAY, start_show=1, game_clr=1 for one cycle; 20 hit pulses -> state=BOSS, boss_show=1, score=20.
- PLAY with miss_cnt=4 and score=19, hit and miss in the same cycle -> state=LOSE, lose_show=1, score=20, miss_cnt=5.
- BOSS, boss_cleared -> WIN; 179 frame_ticks keep win_show=1; 180th tick -> IDLE, start_show=0.
- LOSE, enter_pressed after 10 ticks -> IDLE next cycle; a subsequent enter_pressed -> PLAY with score=0 and a game_clr pulse.
- With BOSS_STAGE_EN undefined, 20 hits -> WIN directly; boss_show stays 0 throughout.
